concat_scale_ctrl: RTL and testbench

Sequencer that feeds the concat re-quantisation multiplier datapath. Each output pixel is built from two producer branches (A then B), and every word is paired with that branch's 32-bit scale. The block owns the datapath valid-tracking across its fixed latency, because the datapath has no stall. It issues only against downstream credits, so the output FIFO can never overflow.

---
 rtl/concat_scale_ctrl_pkg.sv | 29 ++
 rtl/concat_scale_ctrl_if.sv | 27 ++
 rtl/concat_scale_credit.sv | 41 ++++
 rtl/concat_scale_ctrl.sv | 148 ++++++++++++++
 tb/tb_concat_scale_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/concat_scale_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the concat re-quantisation sequencer.
// Datapath word width is derived from the picture/channel fan-in of the multiplier array.
package concat_scale_ctrl_pkg;

  localparam int PICTURE_NUM       = 4;
  localparam int RE_CHANNEL_IN_NUM = 4;
  localparam int DATA_W            = PICTURE_NUM * RE_CHANNEL_IN_NUM * 32;
  localparam int SCALE_W           = 32;
  localparam int DP_LAT            = 4;
  localparam int CREDITS           = 8;
  localparam int CNT_W             = 16;
  localparam int CRED_W            = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A pixel starts on branch A unless A contributes no words.
  function automatic state_t first_branch(input logic [CNT_W-1:0] grp_a);
    return (grp_a == '0) ? ST_RUN_B : ST_RUN_A;
  endfunction

endpackage

// File: rtl/concat_scale_ctrl_if.sv
// Producer, datapath and credit-return signals of the concat scale sequencer.
// Handshake: a word moves on a cycle where valid and ready are both high; valid never waits on ready.
interface concat_scale_ctrl_if;
  import concat_scale_ctrl_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] dp_data;
  logic [SCALE_W-1:0] dp_scale;
  logic              out_valid;
  logic              credit_ret;

  modport master (
    output a_valid, a_data, b_valid, b_data, credit_ret,
    input  a_ready, b_ready, dp_data, dp_scale, out_valid
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, credit_ret,
    output a_ready, b_ready, dp_data, dp_scale, out_valid
  );

endinterface

// File: rtl/concat_scale_credit.sv
// Downstream FIFO credit counter: decrements on issue, increments on return, saturates at full.
// A return while already full is a protocol error and latches a sticky flag.
module concat_scale_credit
  import concat_scale_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_take,
  input  logic              i_ret,
  output logic [CRED_W-1:0] o_credits,
  output logic              o_avail,
  output logic              o_err
);

  logic [CRED_W-1:0] r_cnt;
  logic              r_err;
  logic              w_full;

  assign w_full = (r_cnt == CRED_W'(CREDITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CRED_W'(CREDITS);
      r_err <= 1'b0;
    end else begin
      case ({i_take, i_ret})
        2'b10: r_cnt <= r_cnt - CRED_W'(1);
        2'b01: begin
          if (w_full) r_err <= 1'b1;
          else        r_cnt <= r_cnt + CRED_W'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_credits = r_cnt;
  assign o_avail   = (r_cnt != '0);
  assign o_err     = r_err;

endmodule

// File: rtl/concat_scale_ctrl.sv
// Sequencer for the concat re-quantisation datapath: walks A then B words per pixel,
// pairs each with its branch scale, and tracks valid through the fixed-latency pipe.
module concat_scale_ctrl
  import concat_scale_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_cfg_pixels,
  input  logic [CNT_W-1:0]    i_cfg_grp_a,
  input  logic [CNT_W-1:0]    i_cfg_grp_b,
  input  logic [SCALE_W-1:0]  i_cfg_scale_a,
  input  logic [SCALE_W-1:0]  i_cfg_scale_b,
  concat_scale_ctrl_if.slave  io_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_credit,
  output state_t              o_dbg_state,
  output logic [CRED_W-1:0]   o_dbg_credits
);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cfg_pixels, r_cfg_grp_a, r_cfg_grp_b;
  logic [SCALE_W-1:0]  r_cfg_scale_a, r_cfg_scale_b;
  logic [CNT_W-1:0]    r_grp_cnt, r_pix_cnt;
  logic [DP_LAT:0]     r_vld_sr;
  logic [DATA_W-1:0]   r_dp_data;
  logic [SCALE_W-1:0]  r_dp_scale;

  logic                w_credit_avail;
  logic [CRED_W-1:0]   w_credits;
  logic                w_a_ready, w_b_ready;
  logic                w_issue_a, w_issue_b, w_issue;
  logic                w_grp_last_a, w_grp_last_b, w_grp_wrap;
  logic                w_pix_last, w_pix_end;
  logic                w_empty_cfg;

  assign w_a_ready    = (r_state == ST_RUN_A) && w_credit_avail;
  assign w_b_ready    = (r_state == ST_RUN_B) && w_credit_avail;
  assign w_issue_a    = w_a_ready && io_bus.a_valid;
  assign w_issue_b    = w_b_ready && io_bus.b_valid;
  assign w_issue      = w_issue_a || w_issue_b;
  assign w_grp_last_a = (r_grp_cnt == r_cfg_grp_a - CNT_ONE);
  assign w_grp_last_b = (r_grp_cnt == r_cfg_grp_b - CNT_ONE);
  assign w_grp_wrap   = w_issue_a ? w_grp_last_a : w_grp_last_b;
  assign w_pix_last   = (r_pix_cnt == r_cfg_pixels - CNT_ONE);
  assign w_pix_end    = (w_issue_a && w_grp_last_a && (r_cfg_grp_b == '0)) ||
                        (w_issue_b && w_grp_last_b);
  assign w_empty_cfg  = (i_cfg_pixels == '0) ||
                        ((i_cfg_grp_a == '0) && (i_cfg_grp_b == '0));

  concat_scale_credit u_credit (
    .clk       (clk),
    .rst       (rst),
    .i_take    (w_issue),
    .i_ret     (io_bus.credit_ret),
    .o_credits (w_credits),
    .o_avail   (w_credit_avail),
    .o_err     (o_err_credit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = w_empty_cfg ? ST_DRAIN : first_branch(i_cfg_grp_a);
      end
      ST_RUN_A: begin
        o_busy = 1'b1;
        if (w_issue_a && w_grp_last_a) begin
          if (r_cfg_grp_b != '0) w_state_nxt = ST_RUN_B;
          else if (w_pix_last)   w_state_nxt = ST_DRAIN;
          else                   w_state_nxt = first_branch(r_cfg_grp_a);
        end
      end
      ST_RUN_B: begin
        o_busy = 1'b1;
        if (w_issue_b && w_grp_last_b)
          w_state_nxt = w_pix_last ? ST_DRAIN : first_branch(r_cfg_grp_a);
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        // Leave only once the last word has left the datapath, out_valid stage included.
        if (r_vld_sr == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_pixels  <= '0;
      r_cfg_grp_a   <= '0;
      r_cfg_grp_b   <= '0;
      r_cfg_scale_a <= '0;
      r_cfg_scale_b <= '0;
      r_grp_cnt     <= '0;
      r_pix_cnt     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_cfg_pixels  <= i_cfg_pixels;
        r_cfg_grp_a   <= i_cfg_grp_a;
        r_cfg_grp_b   <= i_cfg_grp_b;
        r_cfg_scale_a <= i_cfg_scale_a;
        r_cfg_scale_b <= i_cfg_scale_b;
        r_grp_cnt     <= '0;
        r_pix_cnt     <= '0;
      end
      if (w_issue)   r_grp_cnt <= w_grp_wrap ? '0 : r_grp_cnt + CNT_ONE;
      if (w_pix_end) r_pix_cnt <= r_pix_cnt + CNT_ONE;
    end
  end

  // The datapath has no stall, so its valid is a pure delay of the issue strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sr   <= '0;
      r_dp_data  <= '0;
      r_dp_scale <= '0;
    end else begin
      r_vld_sr <= {r_vld_sr[DP_LAT-1:0], w_issue};
      if (w_issue) begin
        r_dp_data  <= w_issue_a ? io_bus.a_data : io_bus.b_data;
        r_dp_scale <= w_issue_a ? r_cfg_scale_a : r_cfg_scale_b;
      end
    end
  end

  assign io_bus.a_ready   = w_a_ready;
  assign io_bus.b_ready   = w_b_ready;
  assign io_bus.dp_data   = r_dp_data;
  assign io_bus.dp_scale  = r_dp_scale;
  assign io_bus.out_valid = r_vld_sr[DP_LAT];
  assign o_dbg_state      = r_state;
  assign o_dbg_credits    = w_credits;

endmodule

// File: tb/tb_concat_scale_ctrl.sv
// Directed bench for concat_scale_ctrl: issue order, scale pairing, latency, credits, reset.
module tb_concat_scale_ctrl;
  import concat_scale_ctrl_pkg::*;

  localparam logic [31:0] A_BASE = 32'hA000_0000;
  localparam logic [31:0] B_BASE = 32'hB000_0000;
  localparam logic [31:0] SC_A   = 32'h0001_0003;
  localparam logic [31:0] SC_B   = 32'h0002_0005;

  logic               clk;
  logic               rst;
  logic               i_start;
  logic [CNT_W-1:0]   cfg_pixels, cfg_grp_a, cfg_grp_b;
  logic [31:0]        cfg_scale_a, cfg_scale_b;
  logic               busy, done, err_credit;
  state_t             dbg_state;
  logic [CRED_W-1:0]  dbg_credits;

  concat_scale_ctrl_if bus();

  concat_scale_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_cfg_pixels  (cfg_pixels),
    .i_cfg_grp_a   (cfg_grp_a),
    .i_cfg_grp_b   (cfg_grp_b),
    .i_cfg_scale_a (cfg_scale_a),
    .i_cfg_scale_b (cfg_scale_b),
    .io_bus        (bus),
    .o_busy        (busy),
    .o_done        (done),
    .o_err_credit  (err_credit),
    .o_dbg_state   (dbg_state),
    .o_dbg_credits (dbg_credits)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W+31:0] exp_q[$];
  int  iss_cyc_q[$];
  int  n_chk = 0, n_err = 0;
  int  cyc = 0;
  int  n_a = 0, n_b = 0, n_ov = 0, n_done = 0, n_busy = 0, n_ardy = 0, n_brdy = 0;
  int  done_cyc = 0, last_ov_cyc = 0, start_cyc = 0;
  bit  loop_en = 1'b0;
  bit  man_ret = 1'b0;
  bit  dp_pend = 1'b0;
  bit  [1:0] ov_hist = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_word(input logic [31:0] base, input int idx);
    logic [31:0] w;
    w = base + 32'(idx);
    return {(DATA_W/32){w}};
  endfunction

  // ---------------- monitor / producer (negedge) ----------------
  initial begin
    logic [DATA_W+31:0] e;
    bus.credit_ret = 1'b0;
    bus.a_data = '0;
    bus.b_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.a_data     = mk_word(A_BASE, n_a);
      bus.b_data     = mk_word(B_BASE, n_b);
      bus.credit_ret = loop_en ? ov_hist[1] : man_ret;
      if (dp_pend) begin
        dp_pend = 1'b0;
        if (exp_q.size() == 0) check("sb_underrun", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          check("dp_data_lo", bus.dp_data[63:0], e[63:0]);
          check("dp_data_hi", bus.dp_data[DATA_W-1:DATA_W-64], e[DATA_W-1:DATA_W-64]);
          check("dp_scale", 64'(bus.dp_scale), 64'(e[DATA_W+31:DATA_W]));
        end
      end
      ov_hist = {ov_hist[0], bus.out_valid};
      if (rst) begin
        exp_q.delete();
        iss_cyc_q.delete();
        ov_hist = '0;
      end else begin
        if (bus.out_valid) begin
          n_ov++;
          last_ov_cyc = cyc;
          if (iss_cyc_q.size() == 0) check("ov_unexpected", 64'(iss_cyc_q.size()), 64'd1);
          else check("ov_latency", 64'(cyc - iss_cyc_q.pop_front()), 64'd5);
        end
        if (bus.a_valid && bus.a_ready) begin
          n_a++; iss_cyc_q.push_back(cyc); dp_pend = 1'b1;
        end
        if (bus.b_valid && bus.b_ready) begin
          n_b++; iss_cyc_q.push_back(cyc); dp_pend = 1'b1;
        end
        if (bus.a_ready) n_ardy++;
        if (bus.b_ready) n_brdy++;
        if (busy)        n_busy++;
        if (i_start)     start_cyc = cyc;
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int pix, input int ga, input int gb);
    n_a = 0; n_b = 0; n_ov = 0; n_done = 0; n_busy = 0; n_ardy = 0; n_brdy = 0;
    cfg_pixels = CNT_W'(pix); cfg_grp_a = CNT_W'(ga); cfg_grp_b = CNT_W'(gb);
    cfg_scale_a = SC_A; cfg_scale_b = SC_B;
    for (int p = 0; p < pix; p++) begin
      for (int i = 0; i < ga; i++) exp_q.push_back({SC_A, mk_word(A_BASE, p*ga + i)});
      for (int j = 0; j < gb; j++) exp_q.push_back({SC_B, mk_word(B_BASE, p*gb + j)});
    end
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick(1);
    check("done_seen", 64'(n_done), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; i_start = 1'b0;
    cfg_pixels = '0; cfg_grp_a = '0; cfg_grp_b = '0; cfg_scale_a = '0; cfg_scale_b = '0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_credits", 64'(dbg_credits), 64'd8);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_dp_data", bus.dp_data[63:0], 64'd0);
    check("rst_dp_scale", 64'(bus.dp_scale), 64'd0);
    check("rst_ready", 64'({bus.a_ready, bus.b_ready}), 64'd0);
    check("rst_busy_done_err", 64'({busy, done, err_credit}), 64'd0);

    // 1: two pixels, 3 A + 2 B words each, credits looped back
    loop_en = 1'b1;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    start_frame(2, 3, 2);
    wait_done(300);
    tick(5);
    check("t1_a_issues", 64'(n_a), 64'd6);
    check("t1_b_issues", 64'(n_b), 64'd4);
    check("t1_out_valid", 64'(n_ov), 64'd10);
    check("t1_done_once", 64'(n_done), 64'd1);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t1_credits", 64'(dbg_credits), 64'd8);
    check("t1_busy_low", 64'(busy), 64'd0);

    // 2: no credit return, A-only frame stalls after 8 issues
    loop_en = 1'b0;
    start_frame(4, 4, 0);
    tick(20);
    check("t2_issues_8", 64'(n_a), 64'd8);
    check("t2_a_ready_low", 64'(bus.a_ready), 64'd0);
    check("t2_credits_0", 64'(dbg_credits), 64'd0);
    check("t2_state", 64'(dbg_state), 64'(ST_RUN_A));
    man_ret = 1'b1;
    tick(1);
    man_ret = 1'b0;
    tick(10);
    check("t2_issues_9", 64'(n_a), 64'd9);
    pulse_reset();
    tick(5);
    check("t2_no_done", 64'(n_done), 64'd0);

    // 3: branch A empty
    loop_en = 1'b1;
    start_frame(3, 0, 1);
    wait_done(200);
    tick(3);
    check("t3_a_ready_never", 64'(n_ardy), 64'd0);
    check("t3_b_issues", 64'(n_b), 64'd3);
    check("t3_out_valid", 64'(n_ov), 64'd3);
    check("t3_done_after_ov", 64'(done_cyc - last_ov_cyc), 64'd2);

    // 4: empty frames
    start_frame(0, 1, 1);
    tick(6);
    check("t4_done", 64'(n_done), 64'd1);
    check("t4_done_lat", 64'(done_cyc - start_cyc), 64'd2);
    check("t4_busy_cycles", 64'(n_busy), 64'd1);
    check("t4_no_ready", 64'(n_ardy + n_brdy), 64'd0);
    start_frame(3, 0, 0);
    tick(6);
    check("t4b_done_lat", 64'(done_cyc - start_cyc), 64'd2);
    check("t4b_no_ready", 64'(n_ardy + n_brdy), 64'd0);

    // 5: reset during RUN_B with three words in flight
    start_frame(2, 1, 4);
    for (int i = 0; i < 50 && (n_a + n_b) < 3; i++) tick(1);
    check("t5_inflight", 64'(n_a + n_b), 64'd3);
    check("t5_state_run_b", 64'(dbg_state), 64'(ST_RUN_B));
    pulse_reset();
    check("t5_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_credits", 64'(dbg_credits), 64'd8);
    check("t5_busy", 64'(busy), 64'd0);
    tick(10);
    check("t5_no_done", 64'(n_done), 64'd0);
    check("t5_no_ov", 64'(n_ov), 64'd0);
    start_frame(1, 2, 2);
    wait_done(200);
    tick(5);
    check("t5_clean_ov", 64'(n_ov), 64'd4);
    check("t5_clean_sb", 64'(exp_q.size()), 64'd0);
    check("t5_clean_credits", 64'(dbg_credits), 64'd8);

    // 6: credit overflow error and simultaneous issue/return
    loop_en = 1'b0;
    check("t6_err_clear", 64'(err_credit), 64'd0);
    man_ret = 1'b1;
    tick(1);
    man_ret = 1'b0;
    tick(1);
    check("t6_err_set", 64'(err_credit), 64'd1);
    check("t6_credits_sat", 64'(dbg_credits), 64'd8);
    bus.a_valid = 1'b0;
    start_frame(1, 4, 0);
    bus.a_valid = 1'b1;
    tick(1);
    check("t6_credits_7", 64'(dbg_credits), 64'd7);
    man_ret = 1'b1;
    tick(1);
    man_ret = 1'b0;
    check("t6_issue_and_ret", 64'(dbg_credits), 64'd7);
    tick(1);
    check("t6_credits_6", 64'(dbg_credits), 64'd6);
    wait_done(100);
    tick(3);
    check("t6_a_issues", 64'(n_a), 64'd4);
    check("t6_credits_5", 64'(dbg_credits), 64'd5);
    check("t6_err_sticky", 64'(err_credit), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
